// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between instruction fetch and
// data access. Data requests have priority, and a starvation counter bounds how long a fetch can wait.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LATENCY    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] LP_CNT_LOAD  = 4'(LATENCY - 1);
  localparam logic [3:0] LP_STARVE    = 4'(STARVE_LIM);
  localparam logic [3:0] LP_STARVE_MX = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_I,
    ISSUE_D,
    WAIT_I,
    WAIT_D
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cntNext;
  logic [3:0]    r_starve;
  logic [3:0]    w_starveNext;
  logic          w_grantI;
  logic          w_grantD;
  logic          r_memWe;
  logic [AW-1:0] r_memAddr;
  logic [DW-1:0] r_memWdata;

  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_starveNext = r_starve;
    w_grantI     = 1'b0;
    w_grantD     = 1'b0;
    mem_en       = 1'b0;
    if_ready     = 1'b0;
    dm_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        // A fetch that has lost STARVE_LIM contentions in a row wins the next one.
        if (dm_req && if_req) begin
          if (r_starve >= LP_STARVE) begin
            w_grantI     = 1'b1;
            w_starveNext = 4'd0;
          end else begin
            w_grantD     = 1'b1;
            w_starveNext = (r_starve == LP_STARVE_MX) ? LP_STARVE_MX : r_starve + 4'd1;
          end
        end else if (dm_req) begin
          w_grantD = 1'b1;
        end else if (if_req) begin
          w_grantI     = 1'b1;
          w_starveNext = 4'd0;
        end
        if (w_grantI) begin
          w_stateNext = ISSUE_I;
        end else if (w_grantD) begin
          w_stateNext = ISSUE_D;
        end
      end
      ISSUE_I: begin
        mem_en      = 1'b1;
        w_cntNext   = LP_CNT_LOAD;
        w_stateNext = WAIT_I;
      end
      ISSUE_D: begin
        mem_en      = 1'b1;
        w_cntNext   = LP_CNT_LOAD;
        w_stateNext = WAIT_D;
      end
      WAIT_I: begin
        if (r_cnt == 4'd0) begin
          if_ready    = 1'b1;
          w_stateNext = IDLE;
        end else begin
          w_cntNext = r_cnt - 4'd1;
        end
      end
      WAIT_D: begin
        if (r_cnt == 4'd0) begin
          dm_ready    = 1'b1;
          w_stateNext = IDLE;
        end else begin
          w_cntNext = r_cnt - 4'd1;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_starve   <= 4'd0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_starve <= w_starveNext;
      // Command fields are captured once at grant and held for the whole access.
      if (w_grantD) begin
        r_memWe    <= dm_we;
        r_memAddr  <= dm_addr;
        r_memWdata <= dm_wdata;
      end else if (w_grantI) begin
        r_memWe    <= 1'b0;
        r_memAddr  <= if_addr;
        r_memWdata <= '0;
      end
    end
  end

  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign if_rdata  = if_ready ? mem_rdata : '0;
  assign dm_rdata  = (dm_ready && !r_memWe) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of single accesses,
// plus hand-written contention, reset-abort and LATENCY=1 sequences, with results checked by a scoreboard.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int SLIM = 4;

  typedef struct {
    logic        isIf;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        isIf;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    int          dropAt;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        if_req, dm_req, dm_we, if_ready, dm_ready, mem_en, mem_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if_reqL1, dm_reqL1, dm_weL1, if_readyL1, dm_readyL1, mem_enL1, mem_weL1;
  logic [31:0] if_addrL1, dm_addrL1, dm_wdataL1, if_rdataL1, dm_rdataL1;
  logic [31:0] mem_addrL1, mem_wdataL1, mem_rdataL1;

  int   checks = 0;
  int   errors = 0;
  exp_t sbQ[$];
  exp_t monE;
  logic prevReady = 1'b0;
  vec_t vecs[7];

  mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(LAT), .STARVE_LIM(SLIM)) u_dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(1), .STARVE_LIM(SLIM)) u_dutL1 (
    .clock(clock), .reset(reset),
    .if_req(if_reqL1), .if_addr(if_addrL1), .if_rdata(if_rdataL1), .if_ready(if_readyL1),
    .dm_req(dm_reqL1), .dm_we(dm_weL1), .dm_addr(dm_addrL1), .dm_wdata(dm_wdataL1),
    .dm_rdata(dm_rdataL1), .dm_ready(dm_readyL1),
    .mem_en(mem_enL1), .mem_we(mem_weL1), .mem_addr(mem_addrL1), .mem_wdata(mem_wdataL1),
    .mem_rdata(mem_rdataL1)
  );

  function automatic logic [31:0] memInit(input int idx);
    return (idx == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(idx));
  endfunction

  // Memory model: re-initialised by reset, but the read pipeline keeps
  // flowing so that a return in flight at reset still shows up late.
  logic [31:0]  memArr [0:255];
  logic [31:0]  pipeData [0:LAT-1];
  logic [LAT-1:0] pipeValid;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) memArr[i] <= memInit(i);
    end else if (mem_en && mem_we) begin
      memArr[mem_addr[9:2]] <= mem_wdata;
    end
    pipeValid[0] <= mem_en && !mem_we;
    pipeData[0]  <= memArr[mem_addr[9:2]];
    for (int i = 1; i < LAT; i++) begin
      pipeValid[i] <= pipeValid[i-1];
      pipeData[i]  <= pipeData[i-1];
    end
  end

  assign mem_rdata = pipeValid[LAT-1] ? pipeData[LAT-1] : 32'hBADBAD00;

  always @(posedge clock) begin
    mem_rdataL1 <= mem_enL1 ? memInit(int'(mem_addrL1[9:2])) : 32'hBADBAD01;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every ready strobe is matched against the oldest expected completion.
  always @(negedge clock) begin
    if (if_ready || dm_ready) begin
      checkOutput("bothReady", 32'(if_ready && dm_ready), 32'd0);
      checkOutput("readyTwice", 32'(prevReady), 32'd0);
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedReady", 32'd1, 32'd0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("grantPort", 32'(if_ready), 32'(monE.isIf));
        checkOutput(monE.isIf ? "ifRdata" : "dmRdata", monE.isIf ? if_rdata : dm_rdata, monE.data);
        checkOutput("otherRdata", monE.isIf ? dm_rdata : if_rdata, 32'd0);
      end
    end
    prevReady = if_ready || dm_ready;
  end

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    logic seen;
    @(posedge clock);
    #1;
    if (v.isIf) begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end else begin
      dm_req   = 1'b1;
      dm_we    = v.we;
      dm_addr  = v.addr;
      dm_wdata = v.wdata;
    end
    e.isIf = v.isIf;
    e.data = v.we ? 32'd0 : v.expData;
    sbQ.push_back(e);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clock);
      if (k == 0) checkOutput("memEnIdle", 32'(mem_en), 32'd0);
      if (k == 1) begin
        checkOutput("memEn", 32'(mem_en), 32'd1);
        checkOutput("memWe", 32'(mem_we), 32'(v.we));
      end
      if (k >= 2 && k <= LAT) checkOutput("memEnWait", 32'(mem_en), 32'd0);
      if (k >= 1 && k <= LAT + 1) begin
        checkOutput("memAddr", mem_addr, v.addr);
        checkOutput("memWdata", mem_wdata, v.isIf ? 32'd0 : v.wdata);
      end
      if (if_ready || dm_ready) begin
        seen = 1'b1;
        checkOutput("readyCycle", 32'(k), 32'(LAT + 1));
      end
      if (v.dropAt > 0 && k == v.dropAt - 1) begin
        if_req   = 1'b0;
        dm_req   = 1'b0;
        if_addr  = ~v.addr;
        dm_addr  = ~v.addr;
        dm_wdata = 32'hFFFF0000;
      end
    end
    if (!seen) checkOutput("readyTimeout", 32'd0, 32'd1);
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  initial begin
    int nReady;
    int lastC;
    int firstEn;
    int secondEn;
    int firstRdy;
    exp_t e;

    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    if_reqL1 = 0; if_addrL1 = 0; dm_reqL1 = 0; dm_weL1 = 0; dm_addrL1 = 0; dm_wdataL1 = 0;

    vecs[0] = '{1'b0, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 0};
    vecs[1] = '{1'b0, 1'b1, 32'h80, 32'h1234,     32'h0,        0};
    vecs[2] = '{1'b1, 1'b0, 32'h0,  32'h0,        32'hC0DE0000, 0};
    vecs[3] = '{1'b0, 1'b0, 32'h80, 32'h0,        32'h1234,     0};
    vecs[4] = '{1'b0, 1'b1, 32'h88, 32'h5555AAAA, 32'h0,        2};
    vecs[5] = '{1'b0, 1'b0, 32'h88, 32'h0,        32'h5555AAAA, 0};
    vecs[6] = '{1'b1, 1'b0, 32'h8,  32'h0,        32'hC0DE0002, 0};

    doReset();
    @(negedge clock);
    checkOutput("rstMemEn", 32'(mem_en), 32'd0);
    checkOutput("rstMemWe", 32'(mem_we), 32'd0);
    checkOutput("rstMemAddr", mem_addr, 32'd0);
    checkOutput("rstMemWdata", mem_wdata, 32'd0);
    checkOutput("rstReady", 32'({if_ready, dm_ready}), 32'd0);
    checkOutput("rstRdata", if_rdata | dm_rdata, 32'd0);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Both ports held: grants must go D,D,D,D,I twice, strobes LAT+2 apart.
    doReset();
    @(posedge clock);
    #1;
    if_req = 1'b1; if_addr = 32'h0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    for (int g = 0; g < 10; g++) begin
      e.isIf = ((g % (SLIM + 1)) == SLIM);
      e.data = e.isIf ? 32'hC0DE0000 : 32'hDEADBEEF;
      sbQ.push_back(e);
    end
    nReady = 0;
    lastC  = 0;
    for (int k = 0; k < 120 && nReady < 10; k++) begin
      @(negedge clock);
      if (if_ready || dm_ready) begin
        if (nReady == 0) checkOutput("contFirstReady", 32'(k), 32'(LAT + 1));
        else             checkOutput("contSpacing", 32'(k - lastC), 32'(LAT + 2));
        lastC = k;
        nReady++;
      end
    end
    if (nReady < 10) checkOutput("contTimeout", 32'(nReady), 32'd10);
    if_req = 1'b0;
    dm_req = 1'b0;

    // Reset during WAIT_D: no ready, outputs cleared, late return ignored.
    @(posedge clock);
    #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    @(negedge clock);
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checkOutput("abortNoReadyC2", 32'(dm_ready), 32'd0);
    @(posedge clock);
    #1;
    reset  = 1'b0;
    dm_req = 1'b0;
    @(negedge clock);
    checkOutput("abortDmReady", 32'(dm_ready), 32'd0);
    checkOutput("abortDmRdata", dm_rdata, 32'd0);
    checkOutput("abortMemEn", 32'(mem_en), 32'd0);
    checkOutput("abortMemAddr", mem_addr, 32'd0);
    checkOutput("abortMemWe", 32'(mem_we), 32'd0);
    checkOutput("abortMemWdata", mem_wdata, 32'd0);
    repeat (3) @(negedge clock);
    applyStimulus(vecs[0]);

    // LATENCY=1 instance with a fetch held high.
    @(posedge clock);
    #1;
    if_reqL1 = 1'b1;
    firstEn = -1; secondEn = -1; firstRdy = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (mem_enL1) begin
        if (firstEn < 0) begin
          firstEn = k;
          checkOutput("l1MemAddr", mem_addrL1, 32'd0);
          checkOutput("l1MemWe", 32'(mem_weL1), 32'd0);
          checkOutput("l1MemWdata", mem_wdataL1, 32'd0);
        end else if (secondEn < 0) begin
          secondEn = k;
        end
      end
      if (if_readyL1 && firstRdy < 0) begin
        firstRdy = k;
        checkOutput("l1IfRdata", if_rdataL1, 32'hC0DE0000);
        checkOutput("l1DmSide", 32'(dm_readyL1) | dm_rdataL1, 32'd0);
      end
    end
    if_reqL1 = 1'b0;
    checkOutput("l1FirstEn", 32'(firstEn), 32'd1);
    checkOutput("l1FirstReady", 32'(firstRdy), 32'd2);
    checkOutput("l1SecondEn", 32'(secondEn), 32'd4);

    repeat (6) @(negedge clock);
    checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
